// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
//   Shared definitions for the life_grid engine:
//     - birth/survive masks for the common outer-totalistic rules
//       (bit k set = rule applies with k live neighbours)
//     - FSM state encoding used by life_grid
//     - popcount helper used for both the 8-neighbour count and the
//       per-row population count
// -----------------------------------------------------------------------------
package life_pkg;

    // Conway B3/S23
    localparam logic [8:0] RULE_CONWAY_BIRTH     = 9'b000001000;
    localparam logic [8:0] RULE_CONWAY_SURVIVE   = 9'b000001100;
    // HighLife B36/S23
    localparam logic [8:0] RULE_HIGHLIFE_BIRTH   = 9'b001001000;
    localparam logic [8:0] RULE_HIGHLIFE_SURVIVE = 9'b000001100;

    // Widest vector popcount accepts; callers zero-extend into it.
    // This also bounds the grid WIDTH, since rows are counted whole.
    localparam int POP_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        READY = 2'd3
    } state_e;

    function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < POP_MAX_W; k++) begin
            c = c + {6'd0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/life_rule_cell.sv
// -----------------------------------------------------------------------------
// life_rule_cell
//   One grid cell: the state register, its live-neighbour count and the
//   birth/survive lookup.
//
//   Ports
//     clk_i          clock, all updates on posedge
//     rst_ni         asynchronous active-low reset (cell goes dead)
//     load_en_i      write load_val_i into the cell this edge (wins over step)
//     load_val_i     value written on a load
//     step_en_i      advance one generation this edge
//     neigh_i        the 8 neighbour states (already edge/torus resolved)
//     rule_birth_i   bit k: dead cell with k live neighbours is born
//     rule_survive_i bit k: live cell with k live neighbours survives
//     alive_o        current cell state
//     next_o         state the cell would take on a step (used for stability)
// -----------------------------------------------------------------------------
module life_rule_cell
    import life_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_en_i,
    input  logic       load_val_i,
    input  logic       step_en_i,
    input  logic [7:0] neigh_i,
    input  logic [8:0] rule_birth_i,
    input  logic [8:0] rule_survive_i,
    output logic       alive_o,
    output logic       next_o
);

    logic                 alive_q;
    logic                 alive_d;
    logic [3:0]           n_cnt;
    logic [POP_MAX_W-1:0] neigh_ext;

    always_comb begin
        neigh_ext      = '0;
        neigh_ext[7:0] = neigh_i;
        n_cnt          = 4'(popcount(neigh_ext));
        next_o         = alive_q ? rule_survive_i[n_cnt] : rule_birth_i[n_cnt];
        alive_d        = alive_q;
        if (load_en_i) begin
            alive_d = load_val_i;
        end else if (step_en_i) begin
            alive_d = next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= alive_d;
        end
    end

    assign alive_o = alive_q;

endmodule

// File: rtl/life_grid.sv
// -----------------------------------------------------------------------------
// life_grid
//   WIDTH x HEIGHT Game-of-Life engine with run-time selectable
//   outer-totalistic rule, planar or torus topology, row-wise pattern load
//   and a sequential (one row per cycle) population count after every
//   load or step.
//
//   Ports
//     clock         single clock, posedge
//     reset_n       asynchronous active-low reset
//     load_valid    load_row holds a valid row
//     load_ready    row accepted this cycle (low only while counting)
//     load_row      bit j = cell (row_ptr, j)
//     step_valid    request one generation
//     step_ready    high only in READY
//     rule_birth    birth mask, sampled on the step edge
//     rule_survive  survive mask, sampled on the step edge
//     states        cell (i,j) at bit i*WIDTH+j
//     generation    generations since the last completed load (wraps)
//     population    live cells, valid once done has pulsed
//     done          one-cycle pulse when a load or step has been counted
//     stable        last step left the grid unchanged
//     extinct       population == 0
//
//   WIDTH must not exceed life_pkg::POP_MAX_W.
// -----------------------------------------------------------------------------
module life_grid
    import life_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20,
    parameter int TORUS  = 0,
    parameter int GEN_W  = 16
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [WIDTH-1:0]                   load_row,
    input  logic                               step_valid,
    output logic                               step_ready,
    input  logic [8:0]                         rule_birth,
    input  logic [8:0]                         rule_survive,
    output logic [WIDTH*HEIGHT-1:0]            states,
    output logic [GEN_W-1:0]                   generation,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  population,
    output logic                               done,
    output logic                               stable,
    output logic                               extinct
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int POP_W = $clog2(CELLS + 1);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    state_e              state_q;
    logic [ROW_W-1:0]    row_ptr_q;
    logic [ROW_W-1:0]    row_idx_q;
    logic [POP_W-1:0]    pop_acc_q;
    logic [POP_W-1:0]    population_q;
    logic [GEN_W-1:0]    generation_q;
    logic                done_q;
    logic                stable_q;
    logic                extinct_q;

    logic [CELLS-1:0]     cells;
    logic [CELLS-1:0]     next_cells;
    logic [WIDTH-1:0]     rows [HEIGHT];
    logic                 load_fire;
    logic                 step_fire;
    logic [ROW_W-1:0]     load_sel;
    logic [POP_MAX_W-1:0] row_ext;
    logic [POP_W-1:0]     row_cnt;
    logic [POP_W-1:0]     pop_total;

    assign load_ready = (state_q != COUNT);
    assign step_ready = (state_q == READY);
    assign load_fire  = load_valid && load_ready;
    // A load arriving in READY takes the edge; the step is dropped.
    assign step_fire  = step_valid && step_ready && !load_valid;
    // The first row of a load always lands in row 0, whatever row_ptr holds.
    assign load_sel   = (state_q == LOAD) ? row_ptr_q : '0;

    // Cell array and neighbour wiring. Offsets k = 0..7 walk the 3x3
    // neighbourhood row by row, skipping the centre.
    for (genvar i = 0; i < HEIGHT; i++) begin : g_row
        assign rows[i] = cells[i*WIDTH +: WIDTH];
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            logic [7:0] neigh;
            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int DI = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DJ = (k < 3) ? (k - 1) :
                                    ((k == 3) ? -1 : ((k == 4) ? 1 : (k - 6)));
                localparam int RR = i + DI;
                localparam int CC = j + DJ;
                localparam bit INSIDE = (RR >= 0) && (RR < HEIGHT) &&
                                        (CC >= 0) && (CC < WIDTH);
                localparam int RW = (RR + HEIGHT) % HEIGHT;
                localparam int CW = (CC + WIDTH) % WIDTH;
                if (INSIDE || (TORUS != 0)) begin : g_live
                    assign neigh[k] = cells[RW*WIDTH + CW];
                end else begin : g_edge
                    assign neigh[k] = 1'b0;
                end
            end
            life_rule_cell u_cell (
                .clk_i          (clock),
                .rst_ni         (reset_n),
                .load_en_i      (load_fire && (load_sel == ROW_W'(i))),
                .load_val_i     (load_row[j]),
                .step_en_i      (step_fire),
                .neigh_i        (neigh),
                .rule_birth_i   (rule_birth),
                .rule_survive_i (rule_survive),
                .alive_o        (cells[i*WIDTH + j]),
                .next_o         (next_cells[i*WIDTH + j])
            );
        end
    end

    always_comb begin
        row_ext            = '0;
        row_ext[WIDTH-1:0] = rows[row_idx_q];
        row_cnt            = POP_W'(popcount(row_ext));
        pop_total          = pop_acc_q + row_cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_ptr_q    <= '0;
            row_idx_q    <= '0;
            pop_acc_q    <= '0;
            population_q <= '0;
            generation_q <= '0;
            done_q       <= 1'b0;
            stable_q     <= 1'b0;
            extinct_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, READY: begin
                    if (load_fire) begin
                        row_ptr_q <= ROW_W'(1);
                        state_q   <= LOAD;
                    end else if (step_fire) begin
                        generation_q <= generation_q + GEN_W'(1);
                        stable_q     <= (next_cells == cells);
                        row_idx_q    <= '0;
                        pop_acc_q    <= '0;
                        state_q      <= COUNT;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        if (row_ptr_q == LAST_ROW) begin
                            generation_q <= '0;
                            stable_q     <= 1'b0;
                            row_idx_q    <= '0;
                            pop_acc_q    <= '0;
                            state_q      <= COUNT;
                        end else begin
                            row_ptr_q <= row_ptr_q + ROW_W'(1);
                        end
                    end
                end
                COUNT: begin
                    // Final row folds straight into population so done and
                    // the fresh count appear on the same edge.
                    if (row_idx_q == LAST_ROW) begin
                        population_q <= pop_total;
                        extinct_q    <= (pop_total == '0);
                        done_q       <= 1'b1;
                        state_q      <= READY;
                    end else begin
                        pop_acc_q <= pop_total;
                        row_idx_q <= row_idx_q + ROW_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign states     = cells;
    assign generation = generation_q;
    assign population = population_q;
    assign done       = done_q;
    assign stable     = stable_q;
    assign extinct    = extinct_q;

endmodule

// File: tb/tb_life_grid.sv
`timescale 1ns/1ps
module tb_life_grid;

    localparam logic [8:0] B3  = 9'b000001000;
    localparam logic [8:0] S23 = 9'b000001100;
    localparam logic [8:0] B1  = 9'b000000010;

    // 5x5 planar grid, cell (i,j) at bit i*5+j
    localparam logic [24:0] VERT   = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);
    localparam logic [24:0] HORIZ  = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
    localparam logic [24:0] BLK    = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12);
    localparam logic [24:0] CTR    = (25'd1 << 12);
    localparam logic [24:0] RING   = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 8) | (25'd1 << 11) |
                                     (25'd1 << 13) | (25'd1 << 16) | (25'd1 << 17) | (25'd1 << 18);
    localparam logic [24:0] CORN   = (25'd1 << 0);
    localparam logic [24:0] CORN3  = (25'd1 << 1) | (25'd1 << 5) | (25'd1 << 6);
    localparam logic [24:0] EDGE_V = (25'd1 << 5) | (25'd1 << 10) | (25'd1 << 15);
    localparam logic [24:0] EDGE_H = (25'd1 << 10) | (25'd1 << 11);
    // 8x8 torus, cell (i,j) at bit i*8+j
    localparam logic [63:0] TCORN  = 64'd1;
    localparam logic [63:0] TRING  = (64'd1 << 63) | (64'd1 << 56) | (64'd1 << 57) | (64'd1 << 7) |
                                     (64'd1 << 1) | (64'd1 << 15) | (64'd1 << 8) | (64'd1 << 9);

    typedef struct packed {
        logic [63:0] st;
        logic        chk_st;
        logic [15:0] gen;
        logic [7:0]  pop;
        logic        stb;
        logic        ext;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic        a_load_valid, a_step_valid, a_load_ready, a_step_ready;
    logic [4:0]  a_load_row;
    logic [8:0]  a_birth, a_surv;
    logic [24:0] a_states;
    logic [3:0]  a_gen;
    logic [4:0]  a_pop;
    logic        a_done, a_stable, a_extinct;

    logic        b_load_valid, b_step_valid, b_load_ready, b_step_ready;
    logic [7:0]  b_load_row;
    logic [8:0]  b_birth, b_surv;
    logic [63:0] b_states;
    logic [15:0] b_gen;
    logic [6:0]  b_pop;
    logic        b_done, b_stable, b_extinct;

    life_grid #(.WIDTH(5), .HEIGHT(5), .TORUS(0), .GEN_W(4)) u_a (
        .clock(clock), .reset_n(reset_n),
        .load_valid(a_load_valid), .load_ready(a_load_ready), .load_row(a_load_row),
        .step_valid(a_step_valid), .step_ready(a_step_ready),
        .rule_birth(a_birth), .rule_survive(a_surv),
        .states(a_states), .generation(a_gen), .population(a_pop),
        .done(a_done), .stable(a_stable), .extinct(a_extinct)
    );

    life_grid #(.WIDTH(8), .HEIGHT(8), .TORUS(1), .GEN_W(16)) u_b (
        .clock(clock), .reset_n(reset_n),
        .load_valid(b_load_valid), .load_ready(b_load_ready), .load_row(b_load_row),
        .step_valid(b_step_valid), .step_ready(b_step_ready),
        .rule_birth(b_birth), .rule_survive(b_surv),
        .states(b_states), .generation(b_gen), .population(b_pop),
        .done(b_done), .stable(b_stable), .extinct(b_extinct)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   a_last_done = -1;
    bit   a_chk_period = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic exp_t mk(input logic [63:0] st, input bit chk, input int gen,
                                input int pop, input bit stb, input bit ext);
        exp_t e;
        e.st = st; e.chk_st = chk; e.gen = gen[15:0]; e.pop = pop[7:0];
        e.stb = stb; e.ext = ext;
        return e;
    endfunction

    // Glider .X. / ..X / XXX at rows 1..3, cols 1..3, shifted (s,s) on 8x8 torus
    function automatic logic [63:0] glider_at(input int s);
        logic [63:0] g;
        g = '0;
        g[((1 + s) % 8) * 8 + (2 + s) % 8] = 1'b1;
        g[((2 + s) % 8) * 8 + (3 + s) % 8] = 1'b1;
        g[((3 + s) % 8) * 8 + (1 + s) % 8] = 1'b1;
        g[((3 + s) % 8) * 8 + (2 + s) % 8] = 1'b1;
        g[((3 + s) % 8) * 8 + (3 + s) % 8] = 1'b1;
        return g;
    endfunction

    // Monitors: pop the oldest expectation on every done pulse
    always @(negedge clock) begin
        if (reset_n && a_done) begin
            if (qa.size() == 0) begin
                timeout("a_unexpected_done");
            end else begin
                ea = qa.pop_front();
                if (ea.chk_st) check("a_states", 64'(a_states), ea.st);
                check("a_generation", 64'(a_gen), 64'(ea.gen[3:0]));
                check("a_population", 64'(a_pop), 64'(ea.pop));
                check("a_stable", 64'(a_stable), 64'(ea.stb));
                check("a_extinct", 64'(a_extinct), 64'(ea.ext));
            end
            if (a_chk_period) begin
                if (a_last_done >= 0) check("a_step_period", 64'(cyc - a_last_done), 64'd6);
                a_last_done = cyc;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && b_done) begin
            if (qb.size() == 0) begin
                timeout("b_unexpected_done");
            end else begin
                eb = qb.pop_front();
                if (eb.chk_st) check("b_states", b_states, eb.st);
                check("b_generation", 64'(b_gen), 64'(eb.gen));
                check("b_population", 64'(b_pop), 64'(eb.pop));
                check("b_stable", 64'(b_stable), 64'(eb.stb));
                check("b_extinct", 64'(b_extinct), 64'(eb.ext));
            end
        end
    end

    task automatic a_load(input logic [24:0] g, input bit also_step);
        int n;
        for (int r = 0; r < 5; r++) begin
            @(negedge clock);
            a_load_valid = 1'b1;
            a_load_row   = g[r*5 +: 5];
            if (r == 0 && also_step) a_step_valid = 1'b1;
            if (r == 1) a_step_valid = 1'b0;
            n = 0;
            while (!a_load_ready && n < 200) begin @(negedge clock); n++; end
            if (n >= 200) timeout("a_load_ready");
        end
        @(negedge clock);
        a_load_valid = 1'b0;
        a_step_valid = 1'b0;
    endtask

    task automatic a_step();
        int n;
        @(negedge clock);
        n = 0;
        while (!a_step_ready && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) timeout("a_step_ready");
        a_step_valid = 1'b1;
        @(negedge clock);
        a_step_valid = 1'b0;
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 500) begin @(negedge clock); n++; end
        if (qa.size() != 0) begin timeout("a_drain"); qa.delete(); end
    endtask

    task automatic b_load(input logic [63:0] g);
        int n;
        for (int r = 0; r < 8; r++) begin
            @(negedge clock);
            b_load_valid = 1'b1;
            b_load_row   = g[r*8 +: 8];
            n = 0;
            while (!b_load_ready && n < 200) begin @(negedge clock); n++; end
            if (n >= 200) timeout("b_load_ready");
        end
        @(negedge clock);
        b_load_valid = 1'b0;
    endtask

    task automatic b_step();
        int n;
        @(negedge clock);
        n = 0;
        while (!b_step_ready && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) timeout("b_step_ready");
        b_step_valid = 1'b1;
        @(negedge clock);
        b_step_valid = 1'b0;
    endtask

    task automatic b_drain();
        int n;
        n = 0;
        while (qb.size() != 0 && n < 1000) begin @(negedge clock); n++; end
        if (qb.size() != 0) begin timeout("b_drain"); qb.delete(); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_load_valid = 0; a_step_valid = 0; a_load_row = '0; a_birth = B3; a_surv = S23;
        b_load_valid = 0; b_step_valid = 0; b_load_row = '0; b_birth = B3; b_surv = S23;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #20;
        check("rst_states", 64'(a_states), 64'd0);
        check("rst_generation", 64'(a_gen), 64'd0);
        check("rst_population", 64'(a_pop), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_stable", 64'(a_stable), 64'd0);
        check("rst_extinct", 64'(a_extinct), 64'd1);
        check("rst_load_ready", 64'(a_load_ready), 64'd1);
        check("rst_step_ready", 64'(a_step_ready), 64'd0);
        check("rst_b_extinct", 64'(b_extinct), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Blinker, with load and step attempts ignored while counting
        qa.push_back(mk(64'(VERT), 1, 0, 3, 0, 0));
        a_load(VERT, 0);
        qa.push_back(mk(64'(HORIZ), 1, 1, 3, 0, 0));
        a_step();
        a_load_valid = 1'b1; a_load_row = 5'b11111; a_step_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("a_load_ready_in_count", 64'(a_load_ready), 64'd0);
            check("a_step_ready_in_count", 64'(a_step_ready), 64'd0);
            @(negedge clock);
        end
        a_load_valid = 1'b0; a_step_valid = 1'b0;
        qa.push_back(mk(64'(VERT), 1, 2, 3, 0, 0));
        a_step();

        // Block still life; the load carries a simultaneous step in READY
        qa.push_back(mk(64'(BLK), 1, 0, 4, 0, 0));
        a_load(BLK, 1);
        qa.push_back(mk(64'(BLK), 1, 1, 4, 1, 0));
        a_step();
        a_drain();

        // Held step_valid: one generation every 6 cycles, counter wraps at 16
        for (int k = 2; k <= 17; k++) qa.push_back(mk(64'(BLK), 1, k % 16, 4, 1, 0));
        @(negedge clock);
        a_last_done = -1;
        a_chk_period = 1'b1;
        a_step_valid = 1'b1;
        repeat (91) @(negedge clock);
        a_step_valid = 1'b0;
        a_drain();
        a_chk_period = 1'b0;

        // Single cell dies under B3/S23, then stays dead and stable
        qa.push_back(mk(64'(CTR), 1, 0, 1, 0, 0));
        a_load(CTR, 0);
        qa.push_back(mk(64'd0, 1, 1, 0, 0, 1));
        a_step();
        qa.push_back(mk(64'd0, 1, 2, 0, 1, 1));
        a_step();
        a_drain();

        // B1/S23: centre cell spawns a ring; corner cell sees the planar edge
        a_birth = B1;
        qa.push_back(mk(64'(CTR), 1, 0, 1, 0, 0));
        a_load(CTR, 0);
        qa.push_back(mk(64'(RING), 1, 1, 8, 0, 0));
        a_step();
        a_drain();
        qa.push_back(mk(64'(CORN), 1, 0, 1, 0, 0));
        a_load(CORN, 0);
        qa.push_back(mk(64'(CORN3), 1, 1, 3, 0, 0));
        a_step();
        a_drain();
        a_birth = B3;

        // Blinker against the left edge
        qa.push_back(mk(64'(EDGE_V), 1, 0, 3, 0, 0));
        a_load(EDGE_V, 0);
        qa.push_back(mk(64'(EDGE_H), 1, 1, 2, 0, 0));
        a_step();
        a_drain();

        // Glider on the 8x8 torus returns home after 32 generations
        qb.push_back(mk(glider_at(0), 1, 0, 5, 0, 0));
        b_load(glider_at(0));
        for (int s = 1; s <= 32; s++) begin
            qb.push_back(mk(glider_at(s / 4), (s % 4) == 0, s, 5, 0, 0));
            b_step();
        end
        b_drain();

        // Corner cell with B1 on the torus sees all 8 wrapped neighbours
        b_birth = B1;
        qb.push_back(mk(TCORN, 1, 0, 1, 0, 0));
        b_load(TCORN);
        qb.push_back(mk(TRING, 1, 1, 8, 0, 0));
        b_step();
        b_drain();
        b_birth = B3;

        // Reset in the middle of COUNT
        qa.push_back(mk(64'(BLK), 1, 0, 4, 0, 0));
        a_load(BLK, 0);
        a_drain();
        a_step();
        @(negedge clock);
        #2 reset_n = 1'b0;
        qa.delete();
        #1;
        check("mid_rst_states", 64'(a_states), 64'd0);
        check("mid_rst_population", 64'(a_pop), 64'd0);
        check("mid_rst_generation", 64'(a_gen), 64'd0);
        check("mid_rst_extinct", 64'(a_extinct), 64'd1);
        check("mid_rst_load_ready", 64'(a_load_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        a_step_valid = 1'b1;
        repeat (12) @(negedge clock);
        a_step_valid = 1'b0;
        check("post_rst_step_ready", 64'(a_step_ready), 64'd0);
        check("post_rst_generation", 64'(a_gen), 64'd0);
        check("post_rst_states", 64'(a_states), 64'd0);
        qa.push_back(mk(64'(VERT), 1, 0, 3, 0, 0));
        a_load(VERT, 0);
        a_drain();

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
